modport_dut: RTL and testbench

Loopback crypto block that checks a 64-bit XTEA cipher datapath end to end. It sits behind the `dut_if` interface used by the verification environment. Each captured `message` is encrypted with a fixed key, then decrypted with the same key. The recovered plaintext is presented on `decrypted_msg`, so a correct implementation always returns the captured message unchanged.

---
 rtl/modport_dut.sv | 95 +++++++++
 tb/tb_modport_dut.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/modport_dut.sv
// XTEA loopback: each captured 64-bit message is encrypted then decrypted with
// KEY, one cipher cycle per clock, and the recovered block is registered out.
module modport_dut #(
  parameter logic [127:0] KEY    = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
  parameter int unsigned  ROUNDS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] message,
  output logic [63:0] decrypted_msg
);

  localparam int unsigned    CW    = $clog2(ROUNDS + 1);
  localparam logic [31:0]    DELTA = 32'h9E37_79B9;
  localparam logic [CW-1:0]  LAST  = CW'(ROUNDS - 1);

  typedef enum logic [1:0] {IDLE, ENC, DEC} state_t;

  state_t        state;
  logic [31:0]   v0, v1, sum;
  logic [CW-1:0] cnt;

  logic [31:0] enc_v0, enc_v1, enc_sum;
  logic [31:0] dec_v0, dec_v1, dec_sum;

  // k[0] is the most significant key word
  function automatic logic [31:0] key_word(input logic [1:0] i);
    case (i)
      2'd0:    return KEY[127:96];
      2'd1:    return KEY[95:64];
      2'd2:    return KEY[63:32];
      default: return KEY[31:0];
    endcase
  endfunction

  function automatic logic [31:0] mix(input logic [31:0] x);
    return ((x << 4) ^ (x >> 5)) + x;
  endfunction

  always_comb begin
    enc_sum = sum + DELTA;
    enc_v0  = v0 + (mix(v1) ^ (sum + key_word(sum[1:0])));
    enc_v1  = v1 + (mix(enc_v0) ^ (enc_sum + key_word(enc_sum[12:11])));

    dec_sum = sum - DELTA;
    dec_v1  = v1 - (mix(v0) ^ (sum + key_word(sum[12:11])));
    dec_v0  = v0 - (mix(dec_v1) ^ (dec_sum + key_word(dec_sum[1:0])));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      v0            <= '0;
      v1            <= '0;
      sum           <= '0;
      cnt           <= '0;
      decrypted_msg <= '0;
    end else begin
      case (state)
        IDLE: begin
          v0    <= message[63:32];
          v1    <= message[31:0];
          sum   <= '0;
          cnt   <= '0;
          state <= ENC;
        end
        ENC: begin
          v0  <= enc_v0;
          v1  <= enc_v1;
          sum <= enc_sum;
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= DEC;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DEC: begin
          v0  <= dec_v0;
          v1  <= dec_v1;
          sum <= dec_sum;
          if (cnt == LAST) begin
            cnt           <= '0;
            decrypted_msg <= {dec_v0, dec_v1};
            state         <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modport_dut.sv
// Bench for modport_dut: default instance plus a ROUNDS=1 / alternate-key
// instance, checked against a software XTEA model and cycle-exact timing.
module tb_modport_dut;

  localparam logic [127:0] KEY0  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] KEY1  = 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;
  localparam logic [31:0]  DELTA = 32'h9E37_79B9;

  logic        clk;
  logic        reset;
  logic [63:0] msg0, msg1;
  logic [63:0] out0, out1;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  modport_dut u_dut0 (
    .clk           (clk),
    .reset         (reset),
    .message       (msg0),
    .decrypted_msg (out0)
  );

  modport_dut #(.KEY(KEY1), .ROUNDS(1)) u_dut1 (
    .clk           (clk),
    .reset         (reset),
    .message       (msg1),
    .decrypted_msg (out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference XTEA encryption (standard algorithm, word order {v0,v1})
  function automatic logic [63:0] xtea_enc(input logic [63:0] blk, input logic [127:0] key,
                                           input int unsigned rounds);
    logic [31:0] y, z, s;
    logic [31:0] k [4];
    for (int i = 0; i < 4; i++) k[i] = key[127 - 32*i -: 32];
    y = blk[63:32];
    z = blk[31:0];
    s = 32'h0;
    for (int unsigned r = 0; r < rounds; r++) begin
      y = y + ((((z << 4) ^ (z >> 5)) + z) ^ (s + k[s & 32'd3]));
      s = s + DELTA;
      z = z + ((((y << 4) ^ (y >> 5)) + y) ^ (s + k[(s >> 11) & 32'd3]));
    end
    return {y, z};
  endfunction

  function automatic logic [63:0] out_of(input bit sel);
    return sel ? out1 : out0;
  endfunction

  function automatic logic [63:0] cipher_of(input bit sel);
    return sel ? {u_dut1.v0, u_dut1.v1} : {u_dut0.v0, u_dut0.v1};
  endfunction

  // Called #1 after an edge; the next edge captures msg. busy_msg is driven
  // during the operation and must be ignored.
  task automatic run_one(input bit sel, input logic [63:0] msg, input logic [63:0] busy_msg,
                         input logic [63:0] prev);
    int unsigned r;
    logic [63:0] exp_ct;
    r      = sel ? 1 : 32;
    exp_ct = xtea_enc(msg, sel ? KEY1 : KEY0, r);
    if (sel) msg1 = msg; else msg0 = msg;
    tick();
    if (sel) msg1 = busy_msg; else msg0 = busy_msg;
    for (int unsigned i = 1; i < 2*r; i++) begin
      tick();
      check(sel ? "hold1" : "hold0", out_of(sel), prev);
      if (i == r) check(sel ? "cipher1" : "cipher0", cipher_of(sel), exp_ct);
    end
    tick();
    check(sel ? "result1" : "result0", out_of(sel), msg);
  endtask

  initial begin
    logic [63:0] prev, m;
    reset = 1'b1;
    msg0  = 64'h0123_4567_89AB_CDEF;
    msg1  = 64'h0;
    tick();
    tick();
    check("reset_out0", out0, 64'h0);
    check("reset_out1", out1, 64'h0);

    reset = 1'b0;
    run_one(0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 64'h0);

    run_one(0, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 64'h0123_4567_89AB_CDEF);
    run_one(0, 64'h0, {$urandom, $urandom}, 64'hDEAD_BEEF_CAFE_F00D);

    run_one(0, 64'h0, {$urandom, $urandom}, 64'h0);
    run_one(0, 64'hFFFF_FFFF_FFFF_FFFF, {$urandom, $urandom}, 64'h0);
    run_one(0, 64'h8000_0000_0000_0001, {$urandom, $urandom}, 64'hFFFF_FFFF_FFFF_FFFF);

    // asynchronous reset between edges
    #3;
    msg0  = 64'hFFFF_FFFF_FFFF_FFFF;
    reset = 1'b1;
    #1;
    check("async_reset", out0, 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_held", out0, 64'h0);
    end

    // abort a message in flight
    msg0  = 64'h1111_2222_3333_4444;
    reset = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) tick();
    reset = 1'b1;
    #1;
    check("abort_reset", out0, 64'h0);
    tick();
    msg0  = 64'h5555_6666_7777_8888;
    reset = 1'b0;
    run_one(0, 64'h5555_6666_7777_8888, {$urandom, $urandom}, 64'h0);

    // realign both instances, then random sweep on the ROUNDS=1 instance
    reset = 1'b1;
    tick();
    reset = 1'b0;
    prev  = 64'h0;
    for (int i = 0; i < 200; i++) begin
      m = {$urandom, $urandom};
      run_one(1, m, {$urandom, $urandom}, prev);
      prev = m;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
